// File: rtl/hack_pkg.sv
// Shared Hack datapath definitions: word width, multiplier iteration count and FSM states.
package hack_pkg;

  localparam int HACK_W    = 16;
  localparam int MUL_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/hack_mul16_seq_if.sv
// Start/done handshake bundle between the ALU (master) and the sequential multiplier (slave).
interface hack_mul16_seq_if;
  import hack_pkg::*;

  logic              start;
  logic [HACK_W-1:0] a;
  logic [HACK_W-1:0] b;
  logic              busy;
  logic              done;
  logic [HACK_W-1:0] product;
  logic              overflow;

  modport master (
    output start, a, b,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, overflow
  );

endinterface

// File: rtl/pp_gate32.sv
// 32-bit word AND single bit: the partial product feeding the multiplier accumulator.
module pp_gate32 (
  input  logic [31:0] word,
  input  logic        sel,
  output logic [31:0] pp
);

  assign pp = word & {32{sel}};

endmodule

// File: rtl/hack_mul16_seq.sv
// Sequential 16x16 shift-and-add multiplier returning the low product half and an unsigned overflow flag.
// Optional build macro HACK_MUL16_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module hack_mul16_seq
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  hack_mul16_seq_if.slave   bus
);

  mul_state_t        state_r;
  mul_state_t        state_next_s;
  logic [31:0]       acc_r;
  logic [31:0]       mcand_r;
  logic [HACK_W-1:0] mplier_r;
  logic [3:0]        count_r;
  logic [HACK_W-1:0] product_r;
  logic              overflow_r;
  logic              busy_r;
  logic              done_r;

  logic [31:0]       pp_s;
  logic [31:0]       acc_next_s;
  logic [HACK_W-1:0] mplier_next_s;
  logic              last_iter_s;

  pp_gate32 u_pp_gate (
    .word (mcand_r),
    .sel  (mplier_r[0]),
    .pp   (pp_s)
  );

  // Datapath next values for one shift-and-add iteration and the RUN exit condition
  always_comb begin
    acc_next_s    = acc_r + pp_s;
    mplier_next_s = mplier_r >> 1;
`ifdef HACK_MUL16_EARLY_EXIT_EN
    last_iter_s   = (count_r == 4'(MUL_ITERS - 1)) || (mplier_next_s == 16'd0);
`else
    last_iter_s   = (count_r == 4'(MUL_ITERS - 1));
`endif
  end

  // FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register; busy/done are registered from the next state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, iteration registers and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= 32'd0;
      mcand_r    <= 32'd0;
      mplier_r   <= 16'd0;
      count_r    <= 4'd0;
      product_r  <= 16'd0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            acc_r    <= 32'd0;
            mcand_r  <= {16'd0, bus.a};
            mplier_r <= bus.b;
            count_r  <= 4'd0;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_next_s;
          count_r  <= count_r + 4'd1;
          if (last_iter_s) begin
            product_r  <= acc_next_s[15:0];
            overflow_r <= |acc_next_s[31:16];
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.product  = product_r;
  assign bus.overflow = overflow_r;

endmodule
